// File: rtl/memalu_sched_pkg.sv
// Shared types for the memory-address ALU and its scheduler.
// Arbitration mode is selected by MEMALU_SCHED_RR_EN (see memalu_sched_pick).
package memalu_sched_pkg;

    typedef enum logic [1:0] {
        MEMALU_OP_ADD    = 2'd0,
        MEMALU_OP_INCR   = 2'd1,
        MEMALU_OP_OFFSET = 2'd2
    } memalu_op_t;

    typedef enum logic [1:0] {
        REG_OP_NONE  = 2'd0,
        REG_OP_READ  = 2'd1,
        REG_OP_WRITE = 2'd2
    } reg_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EXEC = 2'd2
    } memalu_sched_state_t;

    localparam int unsigned MEMALU_SCHED_MAX_REQ = 8;

    function automatic int unsigned memalu_sched_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/memalu_sched_pick.sv
// Combinational winner selection for memalu_sched.
// MEMALU_SCHED_RR_EN defined: round-robin from start+1; undefined: lowest index wins.
module memalu_sched_pick
    import memalu_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IW      = memalu_sched_idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] reqs,
    input  logic [IW-1:0]      start,
    output logic [IW-1:0]      winner,
    output logic               valid
);

    logic [IW-1:0] sel;

`ifdef MEMALU_SCHED_RR_EN
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        sel    = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            sel = IW'((32'(start) + i) % NUM_REQ);
            if (!valid && reqs[sel]) begin
                valid  = 1'b1;
                winner = sel;
            end
        end
    end
`else
    logic start_unused;
    assign start_unused = ^start;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        sel    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sel = IW'(i);
            if (!valid && reqs[sel]) begin
                valid  = 1'b1;
                winner = sel;
            end
        end
    end
`endif

endmodule

// File: rtl/memalu_sched.sv
// Sequencer/arbiter for the shared address ALU: IDLE -> LOAD (operand read) -> EXEC (result write).
// Define MEMALU_SCHED_RR_EN for round-robin arbitration; default is fixed priority.
module memalu_sched
    import memalu_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  memalu_op_t [NUM_REQ-1:0]  req_op,
    input  logic                      hold,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        ack,
    output memalu_op_t                alu_mode,
    output reg_op_t                   alu_control,
    output logic                      busy
);

    localparam int unsigned IW = memalu_sched_idx_w(NUM_REQ);

    memalu_sched_state_t state, state_next;
    logic [IW-1:0]       w_q;
    memalu_op_t          op_q;
    logic [NUM_REQ-1:0]  w_onehot;
    logic [NUM_REQ-1:0]  cand;
    logic [IW-1:0]       pick_idx;
    logic                pick_valid;
    logic [IW-1:0]       start_ptr;
    logic                take;

    assign w_onehot = NUM_REQ'(1) << w_q;

    // The current winner's request is consumed in EXEC, so it cannot re-win back-to-back.
    assign cand = (state == IDLE) ? req :
                  (state == EXEC) ? (req & ~w_onehot) : '0;

    memalu_sched_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .reqs   (cand),
        .start  (start_ptr),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

`ifdef MEMALU_SCHED_RR_EN
    logic [IW-1:0] ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= IW'(NUM_REQ - 1);
        end else if (take) begin
            ptr <= pick_idx;
        end
    end

    assign start_ptr = ptr;
`else
    assign start_ptr = '0;
`endif

    always_comb begin
        state_next  = state;
        take        = 1'b0;
        gnt         = '0;
        ack         = '0;
        alu_control = REG_OP_NONE;
        busy        = 1'b0;
        unique case (state)
            IDLE: begin
                take = !hold && pick_valid;
                if (take) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                gnt         = w_onehot;
                alu_control = REG_OP_READ;
                busy        = 1'b1;
                state_next  = EXEC;
            end
            EXEC: begin
                gnt         = w_onehot;
                ack         = w_onehot;
                alu_control = REG_OP_WRITE;
                busy        = 1'b1;
                take        = !hold && pick_valid;
                state_next  = take ? LOAD : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            w_q   <= '0;
            op_q  <= MEMALU_OP_ADD;
        end else begin
            state <= state_next;
            if (take) begin
                w_q  <= pick_idx;
                op_q <= req_op[pick_idx];
            end
        end
    end

    assign alu_mode = op_q;

endmodule
